// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Index 0 is the rightmost entry; nibbles 10..15 never come out of a valid conversion.
  localparam logic [15:0][6:0] SEG_LUT = {
    BLANK, BLANK, BLANK, BLANK, BLANK, BLANK,
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  function automatic logic [31:0] MAX_VALUE(input int num_digits);
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < num_digits; i++) begin
      m = m * 32'd10;
    end
    return m - 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary to BCD converter, one bit per cycle.
// Latency IN_WIDTH cycles after load; load is ignored while busy, valid pulses with the final bcd.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IN_WIDTH   = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_WIDTH-1:0]     value,
  input  logic                    load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    valid
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  conv_state_t state, state_nxt;
  logic [IN_WIDTH-1:0]    bin_q, bin_nxt;
  logic [BW-1:0]          acc_q, acc_nxt, acc_adj;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [BW+IN_WIDTH-1:0] shifted;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Carry out of the top nibble falls off the end; the overflow flag covers that case.
  assign shifted = {acc_adj, bin_q} << 1;
  assign bcd     = shifted[BW+IN_WIDTH-1:IN_WIDTH];
  assign busy    = (state == CONVERT);

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          bin_nxt   = value;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        acc_nxt = shifted[BW+IN_WIDTH-1:IN_WIDTH];
        bin_nxt = shifted[IN_WIDTH-1:0];
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          valid     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      bin_q <= bin_nxt;
      acc_q <= acc_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed common-anode seven-segment driver; optional leading-zero blanking via DISPLAY_SCAN_LZB_EN.
// New value reaches the pins IN_WIDTH+1 cycles after load; loads while busy are dropped.
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int IN_WIDTH         = 14,
  parameter int REFRESH_OVERFLOW = 2**19 - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [6:0]            led_select
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int RW = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BW-1:0]         conv_bcd;
  logic                  conv_valid;
  logic [BW-1:0]         digits_q;
  logic                  overflow_q;
  logic [RW-1:0]         refresh_cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            nib;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .IN_WIDTH   (IN_WIDTH)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .bcd   (conv_bcd),
    .valid (conv_valid)
  );

  assign overflow = overflow_q;

  // Flag is taken at load time so dashes appear before the conversion finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      if (load && !busy) begin
        overflow_q <= (32'(value) > MAX_VALUE(NUM_DIGITS));
      end
      if (conv_valid) begin
        digits_q <= conv_bcd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == RW'(REFRESH_OVERFLOW)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run && (digits_q[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end
`endif

  always_comb begin
    nib     = digits_q[4*int'(idx) +: 4];
    seg_nxt = SEG_LUT[nib];
`ifdef DISPLAY_SCAN_LZB_EN
    if ((idx != '0) && lead_zero[idx]) begin
      seg_nxt = BLANK;
    end
`endif
    if (overflow_q) begin
      seg_nxt = DASH;
    end
    sel_nxt      = '1;
    sel_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_select <= '1;
      led_select   <= BLANK;
    end else begin
      digit_select <= sel_nxt;
      led_select   <= seg_nxt;
    end
  end

endmodule

// File: doc/display_scan.md
# display_scan

Parametrised multiplexed seven-segment driver and next generation of the team's fixed 4-digit display block. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes NUM_DIGITS common-anode digits and flags values the display cannot show. It sits between board-level inputs (switches, counters) and the digit/segment pins.

## Interface
- NUM_DIGITS, 4: digits driven, 1..8.
- IN_WIDTH, 14: binary input width, 1..27.
- REFRESH_OVERFLOW, 2**19-1: terminal count of the per-digit refresh counter; each digit is lit for REFRESH_OVERFLOW+1 cycles.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- value  input  IN_WIDTH  unsigned binary to display.
- load  input  1  one-cycle strobe; samples value when busy=0.
- busy  output  1  conversion in progress.
- overflow  output  1  latched value > 10**NUM_DIGITS-1.
- digit_select  output  NUM_DIGITS  active-low digit enables; bit 0 is the rightmost (least significant) digit.
- led_select  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- Converter FSM states:
  - IDLE: on load=1, capture value into the shift register, clear the BCD accumulator and iteration counter, set overflow = (value > MAX_VALUE), and go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After IN_WIDTH iterations, commit the accumulator to the digit register and return to IDLE.
- load is ignored in CONVERT. The current conversion is not disturbed and overflow is not updated.
- BCD accumulator is 4*NUM_DIGITS bits. Carries out of the top nibble are discarded; this is harmless because overflow overrides the display.
- The digit register holds the last completed result. The display shows the old value until commit, with no partial digits.
- Refresh:
  - The counter counts 0..REFRESH_OVERFLOW and then wraps to 0.
  - On wrap, the digit index advances 0→1→…→NUM_DIGITS-1→0.
- Output per cycle:
  - digit_select = all ones except bit[index] = 0.
  - led_select = SEG_LUT[digit register nibble at index].
  - If overflow=1, led_select = DASH (7'b0111111) on every digit.
- Nibbles 10..15 cannot occur. If one does, SEG_LUT maps it to BLANK (7'b1111111).
- Reset mid-conversion: state→IDLE, the conversion is abandoned, and the digit register returns to zero.

## Timing
- Reset values:
  - busy=0, overflow=0.
  - digit_select all ones, led_select 7'b1111111.
  - Refresh counter 0, index 0, digit register 0.
- digit_select and led_select are registered. On the first edge after reset release they show digit 0 = '0' (7'b1000000).
- load is sampled at edge E0. busy=1 from E0 through E_IN_WIDTH and falls at E_IN_WIDTH, when the result commits. busy is high for exactly IN_WIDTH cycles.
- The new value appears on the outputs at E_IN_WIDTH+1 (one register stage).
- overflow updates at E0, so dashes can precede the commit by up to IN_WIDTH cycles.
- A load on the same edge that busy falls is ignored. load is accepted from the next cycle.
- A commit landing on a refresh wrap edge is legal. The new index shows the new data one cycle later.

## Configuration
- DISPLAY_SCAN_LZB_EN defined: leading-zero blanking.
  - Digit i > 0 is BLANK when it and every more-significant nibble are zero.
  - Digit 0 always shows its value.
  - Blanking does not apply when overflow=1.
- DISPLAY_SCAN_LZB_EN undefined: every digit shows its nibble, including leading zeros.

## Structure
- The display_pkg package holds:
  - SEG_LUT, a 16-entry constant segment table.
  - The DASH and BLANK constants.
  - The converter state typedef (IDLE, CONVERT).
  - A MAX_VALUE function of NUM_DIGITS.
- Sub-module bin2bcd_seq contains the iterative double-dabble FSM, with ports clk, reset, value, load, busy, bcd, valid.
- display_scan instantiates bin2bcd_seq and implements the refresh counter, digit mux, overflow and blanking logic.

## Test plan
All scenarios use NUM_DIGITS=4, IN_WIDTH=14, REFRESH_OVERFLOW=3.
- Reset assert, then release -> during reset digit_select=4'b1111 and led_select=7'b1111111. Next edge: digit_select=4'b1110, led_select=7'b1000000. Digits scan every 4 cycles.
- load with value=1234 -> busy high exactly 14 cycles. Scan then shows digit0=4 (7'b0011001), digit1=3, digit2=2, digit3=1. overflow=0.
- load with value=10000 -> overflow=1 at the load edge. All four digits show 7'b0111111.
- load with value=42, then load with value=99 three cycles later -> the second load is ignored and the display shows 0042 (or blanked-leading 42).
- load with value=7 -> with DISPLAY_SCAN_LZB_EN, digits 1..3 are 7'b1111111 and digit0 is 7'b1111000. Without the macro, digits 1..3 are 7'b1000000.
- Assert reset at cycle 5 of a conversion of 9999 -> busy=0 and outputs return to reset values. After release, the display shows 0000 and the next load converts normally.
